tpu_tile_seq: RTL and testbench
===============================

TPU_TILE_SEQ -- requirements
Module: tpu_tile_seq

Interface
REQ-001 SHALL have parameter SA_N, default 4: systolic array edge (rows = cols), legal 2..16.
REQ-002 SHALL have parameter DATA_BITS, default 32: operand word width; one word feeds one array row/column.
REQ-003 SHALL have parameter ACC_BITS, default 128: result word width per array row.
REQ-004 SHALL have parameter ADDR_BITS, default 16: A/B/C buffer address width.
REQ-005 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: start  in  1  job request; K, M, N  in  8 each  matrix dims, sampled on accepted start.
REQ-007 SHALL have ports: busy, idle, done, err  out  1 each  status; done/err are single-cycle pulses.
REQ-008 SHALL have ports: a_addr, b_addr  out  ADDR_BITS; a_rdata, b_rdata  in  DATA_BITS  (1-cycle read latency).
REQ-009 SHALL have ports: a_buf, b_buf  out  SA_N*DATA_BITS  array operands (word i at bits [i*DATA_BITS +: DATA_BITS]).
REQ-010 SHALL have ports: sa_clr  out  1  array clear; sa_go  out  1  compute pulse; sa_done  in  1  compute finished.
REQ-011 SHALL have ports: sa_result  in  SA_N*ACC_BITS  array row results, valid while sa_done=1.
REQ-012 SHALL have ports: c_we  out  1; c_addr  out  ADDR_BITS; c_wdata  out  ACC_BITS  result write port.

Function
REQ-013 SHALL compute tile counts KT=ceil(K/SA_N), MT=ceil(M/SA_N), NT=ceil(N/SA_N) from captured dims.
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored with no state change.
REQ-015 SHALL, on accepted start with K, M or N equal to 0, pulse err one cycle, stay IDLE, never assert busy.
REQ-016 SHALL use states IDLE, LOAD, COMPUTE, ACCUM, WRITE, NEXT; IDLE->LOAD on legal start.
REQ-017 SHALL iterate nt outer, mt middle, kt inner; each (mt,nt) pair has its own accumulator bank of SA_N x ACC_BITS, cleared on entry to the pair.
REQ-018 LOAD SHALL last SA_N+1 cycles: cycle i<SA_N drives a_addr = mt*K + kt*SA_N + i, b_addr = nt*K + kt*SA_N + i; cycle i+1 captures word i.
REQ-019 LOAD SHALL capture 0 instead of rdata for word i when kt*SA_N+i >= K (K padding).
REQ-020 LOAD->COMPUTE: sa_clr held 1 during LOAD, 0 in COMPUTE; sa_go pulses on the first COMPUTE cycle only.
REQ-021 COMPUTE SHALL wait for sa_done with no timeout; sa_done outside COMPUTE SHALL be ignored.
REQ-022 COMPUTE->ACCUM on sa_done: ACCUM (1 cycle) adds sa_result row r to accumulator r, modulo 2^ACC_BITS.
REQ-023 ACCUM SHALL go to LOAD with kt+1 if kt<KT-1, else to WRITE.
REQ-024 WRITE SHALL take SA_N cycles: cycle j asserts c_we=1 with c_addr = nt*M + mt*SA_N + j, c_wdata = accumulator j, only if mt*SA_N+j < M; padded rows SHALL keep c_we=0.
REQ-025 NEXT (1 cycle) SHALL advance mt (wrap to 0 and increment nt at MT-1) and go to LOAD with kt=0; after last (mt,nt) it SHALL go to IDLE and pulse done.
REQ-026 SHALL drive busy=1 in every non-IDLE state; idle = ~busy; address arithmetic SHALL truncate to ADDR_BITS without flagging.
REQ-027 SHALL hold a_buf/b_buf stable from end of LOAD through end of COMPUTE.

Reset
REQ-028 SHALL, on rst_n=0 at any clk edge, go to IDLE and clear all counters and accumulators; busy=0, idle=1, done=0, err=0, c_we=0, sa_go=0, sa_clr=1, addresses=0, a_buf=b_buf=0, c_wdata=0.
REQ-029 SHALL, on reset mid-job, issue no further c_we and not pulse done; next legal start begins a fresh job.

Verification (SA_N=4, sa_done 8 cycles after sa_go unless stated)
REQ-030 K=M=N=4, A/B rows = known values -> 1 LOAD, 1 COMPUTE, 4 writes to c_addr 0..3 with sa_result rows, done pulse, idle=1.
REQ-031 K=8, M=N=4, sa_result rows = 5 each pass -> 2 LOAD/COMPUTE passes, second LOAD reads addrs 4..7, c_wdata=10 at addrs 0..3.
REQ-032 K=6, M=4, N=4 -> second pass captures words 2,3 as 0 regardless of rdata (0xFFFFFFFF driven).
REQ-033 K=4, M=6, N=8 -> 4 tile pairs; writes only to addrs 0..5 and 6..11, 12 c_we pulses total, none for padded rows.
REQ-034 start with N=0 -> err pulse, busy never 1; start asserted during COMPUTE -> ignored, job completes unchanged.
REQ-035 rst_n=0 for 1 cycle during COMPUTE, then sa_done=1 -> no ACCUM, no c_we, no done; outputs at REQ-028 values.

Source files
------------

// File: rtl/tpu_tile_seq.sv
// Tile sequencer: walks a K x M x N job over an SA_N x SA_N systolic array,
// streaming operand words from the A/B buffers and accumulating per-tile results.
module tpu_tile_seq #(
  parameter int SA_N      = 4,
  parameter int DATA_BITS = 32,
  parameter int ACC_BITS  = 128,
  parameter int ADDR_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [7:0]                K,
  input  logic [7:0]                M,
  input  logic [7:0]                N,
  output logic                      busy,
  output logic                      idle,
  output logic                      done,
  output logic                      err,
  output logic [ADDR_BITS-1:0]      a_addr,
  output logic [ADDR_BITS-1:0]      b_addr,
  input  logic [DATA_BITS-1:0]      a_rdata,
  input  logic [DATA_BITS-1:0]      b_rdata,
  output logic [SA_N*DATA_BITS-1:0] a_buf,
  output logic [SA_N*DATA_BITS-1:0] b_buf,
  output logic                      sa_clr,
  output logic                      sa_go,
  input  logic                      sa_done,
  input  logic [SA_N*ACC_BITS-1:0]  sa_result,
  output logic                      c_we,
  output logic [ADDR_BITS-1:0]      c_addr,
  output logic [ACC_BITS-1:0]       c_wdata
);

  localparam int CW = $clog2(SA_N + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_ACCUM, S_WRITE, S_NEXT
  } state_t;

  function automatic logic [7:0] tiles(input logic [7:0] d);
    logic [8:0] s;
    s = {1'b0, d} + 9'(SA_N - 1);
    return 8'(s / 9'(SA_N));
  endfunction

  state_t                           state_q, state_d;
  logic [CW-1:0]                    cyc_q, cyc_d;
  logic [7:0]                       kt_q, kt_d, mt_q, mt_d, nt_q, nt_d;
  logic [7:0]                       k_q, k_d, m_q, m_d;
  logic [7:0]                       ktn_q, ktn_d, mtn_q, mtn_d, ntn_q, ntn_d;
  logic [SA_N-1:0][ACC_BITS-1:0]    acc_q, acc_d;
  logic [SA_N*ACC_BITS-1:0]         res_q, res_d;
  logic [SA_N*DATA_BITS-1:0]        abuf_q, abuf_d, bbuf_q, bbuf_d;
  logic                             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                             sa_clr_q, sa_clr_d, sa_go_q, sa_go_d;
  logic                             c_we_q, c_we_d;
  logic [ADDR_BITS-1:0]             a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [ADDR_BITS-1:0]             c_addr_q, c_addr_d;
  logic [ACC_BITS-1:0]              c_wdata_q, c_wdata_d;

  // State register and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      kt_q      <= '0;
      mt_q      <= '0;
      nt_q      <= '0;
      k_q       <= '0;
      m_q       <= '0;
      ktn_q     <= '0;
      mtn_q     <= '0;
      ntn_q     <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      abuf_q    <= '0;
      bbuf_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sa_clr_q  <= 1'b1;
      sa_go_q   <= 1'b0;
      c_we_q    <= 1'b0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      kt_q      <= kt_d;
      mt_q      <= mt_d;
      nt_q      <= nt_d;
      k_q       <= k_d;
      m_q       <= m_d;
      ktn_q     <= ktn_d;
      mtn_q     <= mtn_d;
      ntn_q     <= ntn_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      abuf_q    <= abuf_d;
      bbuf_q    <= bbuf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sa_clr_q  <= sa_clr_d;
      sa_go_q   <= sa_go_d;
      c_we_q    <= c_we_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      c_addr_q  <= c_addr_d;
      c_wdata_q <= c_wdata_d;
    end
  end

  // Next-state sequencing; outputs are precomputed from the next state so they register in step
  always_comb begin
    logic [31:0] kbase_s;
    logic [31:0] row_s;
    state_d = state_q;
    cyc_d   = cyc_q;
    kt_d    = kt_q;
    mt_d    = mt_q;
    nt_d    = nt_q;
    k_d     = k_q;
    m_d     = m_q;
    ktn_d   = ktn_q;
    mtn_d   = mtn_q;
    ntn_d   = ntn_q;
    acc_d   = acc_q;
    res_d   = res_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // Word i arrives one cycle after its address; words past K are zero padding
    kbase_s = 32'(kt_q) * 32'(SA_N);
    for (int i = 0; i < SA_N; i++) begin
      abuf_d[i*DATA_BITS +: DATA_BITS] = (state_q == S_LOAD && cyc_q == CW'(i + 1)) ?
          (((kbase_s + 32'(i)) >= 32'(k_q)) ? '0 : a_rdata) : abuf_q[i*DATA_BITS +: DATA_BITS];
      bbuf_d[i*DATA_BITS +: DATA_BITS] = (state_q == S_LOAD && cyc_q == CW'(i + 1)) ?
          (((kbase_s + 32'(i)) >= 32'(k_q)) ? '0 : b_rdata) : bbuf_q[i*DATA_BITS +: DATA_BITS];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (K == 8'd0 || M == 8'd0 || N == 8'd0) begin
            err_d = 1'b1;
          end else begin
            k_d     = K;
            m_d     = M;
            ktn_d   = tiles(K);
            mtn_d   = tiles(M);
            ntn_d   = tiles(N);
            kt_d    = 8'd0;
            mt_d    = 8'd0;
            nt_d    = 8'd0;
            cyc_d   = '0;
            acc_d   = '0;
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (cyc_q == CW'(SA_N)) begin
          cyc_d   = '0;
          state_d = S_COMPUTE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_COMPUTE: begin
        if (sa_done) begin
          res_d   = sa_result;
          state_d = S_ACCUM;
        end else begin
          state_d = S_COMPUTE;
        end
      end
      S_ACCUM: begin
        for (int r = 0; r < SA_N; r++) begin
          acc_d[r] = acc_q[r] + res_q[r*ACC_BITS +: ACC_BITS];
        end
        cyc_d = '0;
        if (kt_q < ktn_q - 8'd1) begin
          kt_d    = kt_q + 8'd1;
          state_d = S_LOAD;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cyc_q == CW'(SA_N - 1)) begin
          cyc_d   = '0;
          state_d = S_NEXT;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_NEXT: begin
        kt_d  = 8'd0;
        cyc_d = '0;
        acc_d = '0;
        if (mt_q == mtn_q - 8'd1) begin
          mt_d = 8'd0;
          if (nt_q == ntn_q - 8'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            nt_d    = nt_q + 8'd1;
            state_d = S_LOAD;
          end
        end else begin
          mt_d    = mt_q + 8'd1;
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d   = (state_d != S_IDLE);
    sa_clr_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    sa_go_d  = (state_d == S_COMPUTE) && (state_q == S_LOAD);

    if (state_d == S_LOAD && cyc_d < CW'(SA_N)) begin
      a_addr_d = ADDR_BITS'(32'(mt_d) * 32'(k_d) + 32'(kt_d) * 32'(SA_N) + 32'(cyc_d));
      b_addr_d = ADDR_BITS'(32'(nt_d) * 32'(k_d) + 32'(kt_d) * 32'(SA_N) + 32'(cyc_d));
    end else begin
      a_addr_d = '0;
      b_addr_d = '0;
    end

    // Rows beyond M are padding and never written back
    row_s     = 32'(mt_d) * 32'(SA_N) + 32'(cyc_d);
    c_we_d    = (state_d == S_WRITE) && (row_s < 32'(m_d));
    c_addr_d  = (state_d == S_WRITE) ? ADDR_BITS'(32'(nt_d) * 32'(m_d) + row_s) : '0;
    c_wdata_d = '0;
    for (int j = 0; j < SA_N; j++) begin
      c_wdata_d = (state_d == S_WRITE && cyc_d == CW'(j)) ? acc_d[j] : c_wdata_d;
    end
  end

  assign busy    = busy_q;
  assign idle    = ~busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign a_addr  = a_addr_q;
  assign b_addr  = b_addr_q;
  assign a_buf   = abuf_q;
  assign b_buf   = bbuf_q;
  assign sa_clr  = sa_clr_q;
  assign sa_go   = sa_go_q;
  assign c_we    = c_we_q;
  assign c_addr  = c_addr_q;
  assign c_wdata = c_wdata_q;

endmodule

// File: tb/tb_tpu_tile_seq.sv
// Self-checking bench for tpu_tile_seq: directed and randomized jobs checked against a
// loop-level model of the tiling order, padding and accumulation.
module tb_tpu_tile_seq;

  localparam int SA_N = 4;
  localparam int DB   = 32;
  localparam int AB   = 128;
  localparam int ADB  = 16;

  logic                 clk = 1'b0;
  logic                 rst_n, start;
  logic [7:0]           K, M, N;
  logic                 busy, idle, done, err;
  logic [ADB-1:0]       a_addr, b_addr, c_addr;
  logic [DB-1:0]        a_rdata, b_rdata;
  logic [SA_N*DB-1:0]   a_buf, b_buf;
  logic                 sa_clr, sa_go, sa_done, c_we;
  logic [SA_N*AB-1:0]   sa_result;
  logic [AB-1:0]        c_wdata;

  int checks = 0;
  int errors = 0;

  logic [DB-1:0]        amem [0:255];
  logic [DB-1:0]        bmem [0:255];
  logic [SA_N*AB-1:0]   res_log[$];
  logic [SA_N*DB-1:0]   asnap[$];
  logic [SA_N*DB-1:0]   bsnap[$];
  logic [ADB-1:0]       waddr[$];
  logic [AB-1:0]        wdata[$];
  int                   go_cnt, done_cnt, err_cnt, busy_seen;
  int                   res_mode;
  bit                   skip_stab;

  always #5 clk = ~clk;

  tpu_tile_seq #(.SA_N(SA_N), .DATA_BITS(DB), .ACC_BITS(AB), .ADDR_BITS(ADB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .K(K), .M(M), .N(N),
    .busy(busy), .idle(idle), .done(done), .err(err),
    .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .a_buf(a_buf), .b_buf(b_buf), .sa_clr(sa_clr), .sa_go(sa_go),
    .sa_done(sa_done), .sa_result(sa_result),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata)
  );

  // Buffer memories with one-cycle read latency
  always @(posedge clk) begin
    a_rdata <= amem[a_addr[7:0]];
    b_rdata <= bmem[b_addr[7:0]];
  end

  // Event monitor
  always @(negedge clk) begin
    if (sa_go) go_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (busy) busy_seen++;
    if (c_we) begin
      waddr.push_back(c_addr);
      wdata.push_back(c_wdata);
    end
  end

  task automatic check(input string tag, input logic [AB-1:0] obs, input logic [AB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Array responder: snapshot operands at sa_go, answer 8 cycles later
  initial begin : responder
    logic [SA_N*AB-1:0] v;
    logic [SA_N*DB-1:0] sa_s, sb_s;
    sa_done   = 1'b0;
    sa_result = '0;
    forever begin
      @(negedge clk);
      if (sa_go) begin
        sa_s = a_buf;
        sb_s = b_buf;
        asnap.push_back(a_buf);
        bsnap.push_back(b_buf);
        check("sa_clr_in_compute", sa_clr, 0);
        repeat (7) @(negedge clk);
        for (int r = 0; r < SA_N; r++)
          v[r*AB +: AB] = (res_mode == 1) ? 128'd5 : {$urandom(), $urandom(), $urandom(), $urandom()};
        sa_result = v;
        sa_done   = 1'b1;
        res_log.push_back(v);
        @(negedge clk);
        sa_done = 1'b0;
        if (!skip_stab) begin
          check("a_buf_stable", a_buf, sa_s);
          check("b_buf_stable", b_buf, sb_s);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string t);
    check({t, "_busy"}, busy, 0);
    check({t, "_idle"}, idle, 1);
    check({t, "_done"}, done, 0);
    check({t, "_err"}, err, 0);
    check({t, "_c_we"}, c_we, 0);
    check({t, "_sa_go"}, sa_go, 0);
    check({t, "_sa_clr"}, sa_clr, 1);
    check({t, "_a_addr"}, a_addr, 0);
    check({t, "_b_addr"}, b_addr, 0);
    check({t, "_c_addr"}, c_addr, 0);
    check({t, "_a_buf"}, a_buf, 0);
    check({t, "_b_buf"}, b_buf, 0);
    check({t, "_c_wdata"}, c_wdata, 0);
  endtask

  task automatic run_job(input int k, input int m, input int n, input int mode,
                         input bit ffill, input bit inject);
    int kt_n, mt_n, nt_n, p, widx;
    bit got;
    logic [AB-1:0] acc [SA_N];
    logic [SA_N*DB-1:0] ea, eb;
    logic [ADB-1:0] ew_a[$];
    logic [AB-1:0] ew_d[$];
    for (int i = 0; i < 256; i++) begin
      amem[i] = ffill ? 32'hFFFF_FFFF : $urandom();
      bmem[i] = ffill ? 32'hFFFF_FFFF : $urandom();
    end
    res_mode = mode;
    res_log.delete(); asnap.delete(); bsnap.delete(); waddr.delete(); wdata.delete();
    go_cnt = 0; done_cnt = 0;
    start = 1'b1; K = k[7:0]; M = m[7:0]; N = n[7:0];
    @(negedge clk);
    start = 1'b0; K = 8'($urandom()); M = 8'($urandom()); N = 8'($urandom());
    got = 1'b0;
    for (int c = 0; c < 5000 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1'b1;
      else if (inject && sa_go) start = 1'b1;
    end
    check("done_seen", got, 1);
    check("idle_at_done", idle, 1);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_single_pulse", done, 0);
    repeat (2) @(negedge clk);
    check("done_count", done_cnt, 1);

    kt_n = (k + SA_N - 1) / SA_N;
    mt_n = (m + SA_N - 1) / SA_N;
    nt_n = (n + SA_N - 1) / SA_N;
    check("passes", res_log.size(), kt_n * mt_n * nt_n);
    check("go_pulses", go_cnt, kt_n * mt_n * nt_n);
    if (res_log.size() == kt_n * mt_n * nt_n && asnap.size() == kt_n * mt_n * nt_n) begin
      p = 0;
      for (int nt = 0; nt < nt_n; nt++) begin
        for (int mt = 0; mt < mt_n; mt++) begin
          for (int r = 0; r < SA_N; r++) acc[r] = '0;
          for (int kt = 0; kt < kt_n; kt++) begin
            ea = '0;
            eb = '0;
            for (int i = 0; i < SA_N; i++) begin
              widx = kt * SA_N + i;
              if (widx < k) begin
                ea[i*DB +: DB] = amem[mt * k + widx];
                eb[i*DB +: DB] = bmem[nt * k + widx];
              end
            end
            check("a_operands", asnap[p], ea);
            check("b_operands", bsnap[p], eb);
            for (int r = 0; r < SA_N; r++) acc[r] = acc[r] + res_log[p][r*AB +: AB];
            p++;
          end
          for (int j = 0; j < SA_N; j++) begin
            if (mt * SA_N + j < m) begin
              ew_a.push_back(ADB'(nt * m + mt * SA_N + j));
              ew_d.push_back(acc[j]);
            end
          end
        end
      end
    end
    check("write_count", waddr.size(), ew_a.size());
    if (waddr.size() == ew_a.size()) begin
      foreach (ew_a[i]) begin
        check("c_addr", waddr[i], ew_a[i]);
        check("c_wdata", wdata[i], ew_d[i]);
      end
    end
  endtask

  initial begin
    logic [SA_N*DB-1:0] tmp;
    bit got;
    rst_n = 1'b0; start = 1'b0; K = 8'd0; M = 8'd0; N = 8'd0;
    res_mode = 0; skip_stab = 1'b0;
    go_cnt = 0; done_cnt = 0; err_cnt = 0; busy_seen = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single tile
    run_job(4, 4, 4, 0, 1'b0, 1'b0);

    // Two K passes of constant 5 accumulate to 10
    run_job(8, 4, 4, 1, 1'b0, 1'b0);
    check("k8_wdata_first", wdata[0], 10);

    // K padding with all-ones memory
    run_job(6, 4, 4, 0, 1'b1, 1'b0);
    tmp = asnap[1];
    check("a_pad_words", tmp[SA_N*DB-1:2*DB], 0);
    tmp = bsnap[1];
    check("b_pad_words", tmp[SA_N*DB-1:2*DB], 0);

    // Four tile pairs with padded M rows
    run_job(4, 6, 8, 0, 1'b0, 1'b0);
    check("tile_write_total", waddr.size(), 12);

    // Zero dimension rejected
    err_cnt = 0; busy_seen = 0;
    start = 1'b1; K = 8'd4; M = 8'd4; N = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    @(negedge clk);
    check("err_single", err, 0);
    repeat (4) @(negedge clk);
    check("err_count", err_cnt, 1);
    check("err_never_busy", busy_seen, 0);

    // Start during COMPUTE is ignored
    run_job(5, 7, 3, 0, 1'b0, 1'b1);

    // Reset mid-COMPUTE
    skip_stab = 1'b1;
    start = 1'b1; K = 8'd4; M = 8'd4; N = 8'd4;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (sa_go) got = 1'b1;
    end
    check("rst_test_go_seen", got, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("midjob_reset");
    waddr.delete(); done_cnt = 0; busy_seen = 0;
    repeat (20) @(negedge clk);
    check("rst_no_writes", waddr.size(), 0);
    check("rst_no_done", done_cnt, 0);
    check("rst_stays_idle", busy_seen, 0);
    skip_stab = 1'b0;

    // Fresh job after reset, then random jobs
    run_job(4, 4, 4, 0, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++)
      run_job(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)),
              int'($urandom_range(1, 9)), 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
